gcd_apb_master: RTL and testbench

- Synthesizable APB initiator that replaces firmware for the GCD IP (apb_top_gcd). It configures the IP after reset, accepts operand pairs on a valid/ready stream, and drives the firmware register sequence: poll STS, write DIN, poll STS, read DOUT.
- Returns each result on an output valid/ready stream.
- Sits between a hardware producer/consumer and the APB port of the GCD IP, allowing GCD offload without a CPU.

---
 rtl/gcd_apb_master.sv | 223 ++++++++++++++++++++++
 tb/tb_gcd_apb_master.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_apb_master.sv
// gcd_apb_master: APB initiator that drives the GCD IP without firmware.
// It writes CTRL once after reset. It then takes operand pairs from a valid/ready stream
// and runs the sequence poll STS, write DIN, poll STS, read DOUT. Each result is returned
// on an output valid/ready stream.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_a, i_b, i_valid   operand pair stream in;  o_ready accepts it
//   o_gcd, o_gcd_valid  result stream out;       i_gcd_ready takes it
//   o_busy              FSM not in IDLE
//   o_timeout           one-cycle pulse when a poll phase gives up
//   o_p*, i_prdata, i_pready   APB initiator port
module gcd_apb_master #(
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter logic [2:0]  CTRL_VAL   = 3'b001,
  parameter int unsigned POLL_LIMIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  i_a,
  input  logic [7:0]  i_b,
  input  logic        i_valid,
  output logic        o_ready,
  output logic [7:0]  o_gcd,
  output logic        o_gcd_valid,
  input  logic        i_gcd_ready,
  output logic        o_busy,
  output logic        o_timeout,
  output logic [31:0] o_paddr,
  output logic        o_pwrite,
  output logic        o_psel,
  output logic        o_penable,
  output logic [31:0] o_pwdata,
  input  logic [31:0] i_prdata,
  input  logic        i_pready
);

  localparam logic [2:0] StCfg     = 3'd0;
  localparam logic [2:0] StIdle    = 3'd1;
  localparam logic [2:0] StPollIn  = 3'd2;
  localparam logic [2:0] StWrDin   = 3'd3;
  localparam logic [2:0] StPollOut = 3'd4;
  localparam logic [2:0] StRdDout  = 3'd5;
  localparam logic [2:0] StResp    = 3'd6;

  localparam logic [15:0] PollLim   = 16'(POLL_LIMIT);
  localparam bit          TimeoutEn = (POLL_LIMIT != 0);

  logic [2:0]  state_q, state_d;
  logic        psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [31:0] paddr_q, paddr_d, pwdata_q, pwdata_d;
  logic [7:0]  a_q, a_d, b_q, b_d, gcd_q, gcd_d;
  logic        gcd_valid_q, gcd_valid_d, ready_q, ready_d;
  logic        busy_q, busy_d, timeout_q, timeout_d;
  logic [15:0] cnt_q, cnt_d, cnt_inc;
  logic        xfer_done, poll_expired, launch;

  // Only STS[1:0] and DOUT[7:0] carry meaning.
  logic unused_prdata;
  assign unused_prdata = ^i_prdata[31:8];

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    a_d         = a_q;
    b_d         = b_q;
    gcd_d       = gcd_q;
    gcd_valid_d = gcd_valid_q;
    ready_d     = ready_q;
    timeout_d   = 1'b0;
    cnt_d       = cnt_q;
    launch      = 1'b0;

    xfer_done    = psel_q & penable_q & i_pready;
    cnt_inc      = cnt_q + 16'd1;
    poll_expired = TimeoutEn && (cnt_inc == PollLim);

    case (state_q)
      StCfg: begin
        if (!psel_q) begin
          launch = 1'b1;
        end else if (xfer_done) begin
          state_d = StIdle;
          ready_d = 1'b1;
        end
      end
      StIdle: begin
        if (i_valid && ready_q) begin
          a_d     = i_a;
          b_d     = i_b;
          ready_d = 1'b0;
          cnt_d   = '0;
          state_d = StPollIn;
        end
      end
      StPollIn, StPollOut: begin
        if (!psel_q) begin
          // First STS read of POLL_IN starts one cycle after the accept.
          launch = 1'b1;
        end else if (xfer_done) begin
          if ((state_q == StPollIn) ? i_prdata[1] : i_prdata[0]) begin
            state_d = (state_q == StPollIn) ? StWrDin : StRdDout;
            launch  = 1'b1;
          end else begin
            cnt_d = cnt_inc;
            if (poll_expired) begin
              timeout_d = 1'b1;
              ready_d   = 1'b1;
              state_d   = StIdle;
            end else begin
              launch = 1'b1;
            end
          end
        end
      end
      StWrDin: begin
        if (xfer_done) begin
          cnt_d   = '0;
          state_d = StPollOut;
          launch  = 1'b1;
        end
      end
      StRdDout: begin
        if (xfer_done) begin
          gcd_d       = i_prdata[7:0];
          gcd_valid_d = 1'b1;
          state_d     = StResp;
        end
      end
      StResp: begin
        if (i_gcd_ready) begin
          gcd_valid_d = 1'b0;
          ready_d     = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StCfg;
    endcase

    // SETUP -> ACCESS, and ACCESS ends on pready.
    if (psel_q && !penable_q) begin
      penable_d = 1'b1;
    end else if (xfer_done) begin
      psel_d    = 1'b0;
      penable_d = 1'b0;
    end

    // A launch overrides the end-of-transfer idle so back-to-back SETUPs are possible.
    if (launch) begin
      psel_d    = 1'b1;
      penable_d = 1'b0;
      pwrite_d  = 1'b0;
      pwdata_d  = '0;
      paddr_d   = BASE_ADDR;
      case (state_d)
        StCfg: begin
          pwrite_d = 1'b1;
          pwdata_d = {29'b0, CTRL_VAL};
        end
        StPollIn, StPollOut: paddr_d = BASE_ADDR + 32'h4;
        StWrDin: begin
          paddr_d  = BASE_ADDR + 32'h8;
          pwrite_d = 1'b1;
          pwdata_d = {16'b0, a_q, b_q};
        end
        StRdDout: paddr_d = BASE_ADDR + 32'hC;
        default: ;
      endcase
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StCfg;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      gcd_q       <= '0;
      gcd_valid_q <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      a_q         <= a_d;
      b_q         <= b_d;
      gcd_q       <= gcd_d;
      gcd_valid_q <= gcd_valid_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
      cnt_q       <= cnt_d;
    end
  end

  assign o_ready     = ready_q;
  assign o_gcd       = gcd_q;
  assign o_gcd_valid = gcd_valid_q;
  assign o_busy      = busy_q;
  assign o_timeout   = timeout_q;
  assign o_paddr     = paddr_q;
  assign o_pwrite    = pwrite_q;
  assign o_psel      = psel_q;
  assign o_penable   = penable_q;
  assign o_pwdata    = pwdata_q;

endmodule

// File: tb/tb_gcd_apb_master.sv
// Bench for gcd_apb_master: behavioural GCD slave on the APB side, table vectors,
// randomized operations against a plain-arithmetic reference, and reset corner cases.
module tb_gcd_apb_master;

  localparam logic [31:0] Base      = 32'h0;
  localparam int          PollLimit = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  i_a, i_b, o_gcd;
  logic        i_valid, o_ready, o_gcd_valid, i_gcd_ready, o_busy, o_timeout;
  logic [31:0] o_paddr, o_pwdata, i_prdata;
  logic        o_pwrite, o_psel, o_penable, i_pready;

  gcd_apb_master #(
    .BASE_ADDR (Base),
    .CTRL_VAL  (3'b001),
    .POLL_LIMIT(PollLimit)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_a        (i_a),
    .i_b        (i_b),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_gcd      (o_gcd),
    .o_gcd_valid(o_gcd_valid),
    .i_gcd_ready(i_gcd_ready),
    .o_busy     (o_busy),
    .o_timeout  (o_timeout),
    .o_paddr    (o_paddr),
    .o_pwrite   (o_pwrite),
    .o_psel     (o_psel),
    .o_penable  (o_penable),
    .o_pwdata   (o_pwdata),
    .i_prdata   (i_prdata),
    .i_pready   (i_pready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] ref_gcd(input logic [7:0] a, input logic [7:0] b);
    int x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return 8'(x);
  endfunction

  // Slave model: STS bit1 appears after in_lat failed reads; after a DIN write,
  // bit0 appears after out_lat failed reads. Unused bits carry random junk.
  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    int          waits;
  } xfer_t;

  xfer_t       log_q[$];
  int          cfg_in_lat = 0, cfg_out_lat = 0, cfg_din_wait = 0;
  bit          cfg_rand_wait = 0;
  int          sts_cnt = 0, wait_left = 0, cur_waits = 0;
  bit          din_done = 0, su_valid = 0;
  logic [7:0]  res = '0;
  logic [31:0] su_addr, su_wdata, junk, rd;
  logic        su_write;

  always @(negedge clk) begin
    junk = $urandom;
    if (rst) begin
      i_pready = 1'b0;
      i_prdata = junk;
      su_valid = 0;
    end else if (o_psel && !o_penable) begin
      su_valid = 1;
      su_addr  = o_paddr;
      su_write = o_pwrite;
      su_wdata = o_pwdata;
      if (!o_pwrite) check("read_pwdata_zero", o_pwdata, 0);
      if (cfg_rand_wait) wait_left = $urandom_range(0, 2);
      else wait_left = (o_paddr == Base + 32'h8) ? cfg_din_wait : 0;
      cur_waits = wait_left;
      i_pready  = 1'b0;
      i_prdata  = junk;
    end else if (o_psel && o_penable) begin
      check("apb_hold", {su_valid, o_paddr, o_pwrite, o_pwdata},
            {1'b1, su_addr, su_write, su_wdata});
      if (wait_left > 0) begin
        wait_left--;
        i_pready = 1'b0;
        i_prdata = junk;
      end else begin
        rd = junk;
        if (o_paddr == Base + 32'h4) begin
          rd[1] = din_done ? 1'b0 : (sts_cnt >= cfg_in_lat);
          rd[0] = din_done ? (sts_cnt >= cfg_out_lat) : 1'b0;
          sts_cnt++;
        end else if (o_paddr == Base + 32'hC) begin
          rd[7:0]  = res;
          din_done = 0;
          sts_cnt  = 0;
        end else if (o_paddr == Base + 32'h8 && o_pwrite) begin
          res      = ref_gcd(o_pwdata[15:8], o_pwdata[7:0]);
          din_done = 1;
          sts_cnt  = 0;
        end
        i_pready = 1'b1;
        i_prdata = rd;
        log_q.push_back('{o_paddr, o_pwrite, o_pwdata, cur_waits});
        su_valid = 0;
      end
    end else begin
      if (o_penable) check("penable_without_psel", o_penable, 0);
      i_pready = junk[0];
      i_prdata = $urandom;
    end
  end

  task automatic check_seq(input logic [7:0] a, input logic [7:0] b, input int n_in,
                           input bit din, input int n_out, input bit dout);
    xfer_t exp_q[$];
    for (int i = 0; i < n_in; i++) exp_q.push_back('{Base + 32'h4, 1'b0, 32'h0, 0});
    if (din) exp_q.push_back('{Base + 32'h8, 1'b1, {16'h0, a, b}, 0});
    for (int i = 0; i < n_out; i++) exp_q.push_back('{Base + 32'h4, 1'b0, 32'h0, 0});
    if (dout) exp_q.push_back('{Base + 32'hC, 1'b0, 32'h0, 0});
    check("xfer_count", log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check($sformatf("xfer%0d", i), {log_q[i].addr, log_q[i].write, log_q[i].wdata},
            {exp_q[i].addr, exp_q[i].write, exp_q[i].wdata});
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int in_lat,
                        input int out_lat, input int din_wait, input bit rwait,
                        input int rdy_dly, output int lat, output logic [7:0] g,
                        output bit to);
    int budget, t0;
    lat = -1;
    g   = '0;
    to  = 0;
    budget = 0;
    while (!o_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check("ready_before_op", o_ready, 1);
    cfg_in_lat = in_lat; cfg_out_lat = out_lat; cfg_din_wait = din_wait;
    cfg_rand_wait = rwait; sts_cnt = 0; din_done = 0;
    log_q.delete();
    i_a = a; i_b = b; i_valid = 1'b1;
    @(negedge clk);
    t0 = cyc;
    i_valid = 1'b0; i_a = 8'($urandom); i_b = 8'($urandom);
    check("accept_drops_ready", {o_ready, o_busy}, 2'b01);
    budget = 0;
    while (!o_gcd_valid && !o_timeout && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    lat = cyc - t0;
    if (o_timeout) begin
      to = 1;
      check("timeout_to_idle", {o_ready, o_busy, o_gcd_valid}, 3'b100);
      @(negedge clk);
      check("timeout_pulse_width", o_timeout, 0);
    end else if (o_gcd_valid) begin
      g = o_gcd;
      for (int k = 0; k < rdy_dly; k++) begin
        @(negedge clk);
        check("resp_hold", {o_gcd_valid, o_gcd, o_ready, o_busy}, {1'b1, g, 1'b0, 1'b1});
      end
      i_gcd_ready = 1'b1;
      @(negedge clk);
      i_gcd_ready = 1'b0;
      check("resp_release", {o_gcd_valid, o_ready, o_busy}, 3'b010);
    end else begin
      check("op_done", o_gcd_valid | o_timeout, 1);
    end
  endtask

  typedef struct {
    logic [7:0] a, b;
    int         in_lat, out_lat, din_wait, rdy_dly;
    logic [7:0] exp_gcd;
    int         exp_lat;
    bit         exp_to;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int         lat, n_in, n_out, wsum, in_l, out_l;
    logic [7:0] g, ra, rb;
    bit         to, din, dout;

    vecs[0]  = '{8'd12,  8'd18,  0,    0,    0, 0, 8'd6,   9,  0};
    vecs[1]  = '{8'd12,  8'd18,  0,    0,    3, 0, 8'd6,   12, 0};
    vecs[2]  = '{8'd48,  8'd18,  0,    3,    0, 2, 8'd6,   15, 0};
    vecs[3]  = '{8'd15,  8'd10,  2,    0,    0, 5, 8'd5,   13, 0};
    vecs[4]  = '{8'd0,   8'd7,   0,    1,    0, 0, 8'd7,   11, 0};
    vecs[5]  = '{8'd255, 8'd255, 1,    1,    1, 1, 8'd255, 14, 0};
    vecs[6]  = '{8'd17,  8'd13,  0,    0,    0, 0, 8'd1,   9,  0};
    vecs[7]  = '{8'd0,   8'd0,   0,    0,    0, 0, 8'd0,   9,  0};
    vecs[8]  = '{8'd9,   8'd6,   1000, 0,    0, 0, 8'd0,   17, 1};
    vecs[9]  = '{8'd9,   8'd6,   0,    1000, 0, 0, 8'd0,   21, 1};
    vecs[10] = '{8'd5,   8'd10,  7,    0,    0, 0, 8'd5,   23, 0};
    vecs[11] = '{8'd8,   8'd12,  0,    7,    0, 0, 8'd4,   23, 0};

    rst = 1'b1; i_valid = 1'b0; i_a = '0; i_b = '0; i_gcd_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {o_paddr, o_pwdata, o_pwrite, o_psel, o_penable, o_ready, o_gcd,
                            o_gcd_valid, o_busy, o_timeout}, '0);
    rst = 1'b0;
    @(negedge clk);
    check("cfg_setup", {o_psel, o_penable, o_pwrite, o_paddr, o_pwdata, o_ready},
          {1'b1, 1'b0, 1'b1, Base, 32'h1, 1'b0});
    @(negedge clk);
    check("cfg_access", {o_psel, o_penable, o_ready}, 3'b110);
    @(negedge clk);
    check("cfg_done", {o_psel, o_penable, o_ready, o_busy}, 4'b0010);
    check("cfg_xfer_count", log_q.size(), 1);
    if (log_q.size() == 1)
      check("cfg_xfer", {log_q[0].addr, log_q[0].write, log_q[0].wdata}, {Base, 1'b1, 32'h1});

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].in_lat, vecs[i].out_lat, vecs[i].din_wait, 0,
             vecs[i].rdy_dly, lat, g, to);
      check($sformatf("vec%0d_timeout", i), to, vecs[i].exp_to);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      if (!vecs[i].exp_to) check($sformatf("vec%0d_gcd", i), g, vecs[i].exp_gcd);
      din   = vecs[i].in_lat < PollLimit;
      n_in  = din ? vecs[i].in_lat + 1 : PollLimit;
      dout  = din && vecs[i].out_lat < PollLimit;
      n_out = !din ? 0 : (dout ? vecs[i].out_lat + 1 : PollLimit);
      check_seq(vecs[i].a, vecs[i].b, n_in, din, n_out, dout);
    end

    for (int r = 0; r < 16; r++) begin
      ra    = 8'($urandom);
      rb    = 8'($urandom);
      in_l  = $urandom_range(0, 3);
      out_l = $urandom_range(0, 3);
      run_op(ra, rb, in_l, out_l, 0, 1, $urandom_range(0, 3), lat, g, to);
      wsum = 0;
      foreach (log_q[k]) wsum += log_q[k].waits;
      check("rand_gcd", {to, g}, {1'b0, ref_gcd(ra, rb)});
      check("rand_latency", lat, 9 + 2 * (in_l + out_l) + wsum);
      check_seq(ra, rb, in_l + 1, 1, out_l + 1, 1);
    end

    // Reset while POLL_OUT is still polling.
    begin
      int budget;
      budget = 0;
      while (!o_ready && budget < 200) begin
        @(negedge clk);
        budget++;
      end
      cfg_in_lat = 0; cfg_out_lat = 1000; cfg_din_wait = 0; cfg_rand_wait = 0;
      sts_cnt = 0; din_done = 0;
      log_q.delete();
      i_a = 8'd15; i_b = 8'd10; i_valid = 1'b1;
      @(negedge clk);
      i_valid = 1'b0;
      budget = 0;
      while (log_q.size() < 4 && budget < 100) begin
        @(negedge clk);
        budget++;
      end
      check("reached_poll_out", {o_busy, log_q.size() >= 4}, 2'b11);
      rst = 1'b1;
      @(negedge clk);
      check("rst_abandon", {o_psel, o_penable, o_busy, o_ready, o_gcd_valid, o_timeout}, '0);
      @(negedge clk);
      rst = 1'b0;
      log_q.delete();
      @(negedge clk);
      check("cfg_reissue", {o_psel, o_penable, o_pwrite, o_paddr, o_pwdata},
            {1'b1, 1'b0, 1'b1, Base, 32'h1});
    end
    run_op(8'd15, 8'd10, 0, 0, 0, 0, 1, lat, g, to);
    check("after_reset_gcd", {to, g}, {1'b0, 8'd5});
    check("after_reset_latency", lat, 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
